// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants for mux_rr_arbiter: output-slot state encoding and round-robin pointer wrap.
// Optional packet lock (see mux_rr_arbiter.sv) is enabled by MUX_RR_ARBITER_PKT_LOCK_EN.
package mux_rr_arbiter_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned num_input);
    return (idx == num_input - 1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle for mux_rr_arbiter; in_last/out_last exist only with
// MUX_RR_ARBITER_PKT_LOCK_EN defined.
interface mux_rr_arbiter_if #(
  parameter int unsigned NUM_INPUT  = 4,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 1
);
  logic [NUM_INPUT-1:0]            in_valid;
  logic [NUM_INPUT-1:0]            in_ready;
  logic [DATA_WIDTH*NUM_INPUT-1:0] in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [SEL_WIDTH-1:0]            out_src;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
  logic [NUM_INPUT-1:0]            in_last;
  logic                            out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_src, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_src, out_last
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
`endif
endinterface

// File: rtl/mux_param.sv
// Generic N-way select of a packed bus of DATA_WIDTH-bit slices; out-of-range select yields 0.
module mux_param #(
  parameter int unsigned NUM_INPUT  = 4,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic [SEL_WIDTH-1:0]            sel,
  input  logic [DATA_WIDTH*NUM_INPUT-1:0] data_in,
  output logic [DATA_WIDTH-1:0]           data_out
);

  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < NUM_INPUT; i++) begin
      if (sel == SEL_WIDTH'(i)) data_out = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin scan: first set request at or after ptr, wrapping to index 0.
module rr_pick
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUT = 4,
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic [NUM_INPUT-1:0] req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] winner,
  output logic                 found
);

  // Two passes: indices >= ptr first, then the lowest index overall (necessarily < ptr).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NUM_INPUT; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        found  = 1'b1;
        winner = SEL_WIDTH'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_INPUT; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        winner = SEL_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a one-entry output register through mux_param.
// Define MUX_RR_ARBITER_PKT_LOCK_EN to hold the grant on one source until its in_last beat.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUT  = 4,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_arbiter_if.slave bus
);

  logic [0:0]            state;
  logic [SEL_WIDTH-1:0]  ptr;
  logic [SEL_WIDTH-1:0]  win;
  logic                  found;
  logic                  slot_free;
  logic                  accept;
  logic [NUM_INPUT-1:0]  req;
  logic [NUM_INPUT-1:0]  grant;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SEL_WIDTH-1:0]  out_src_q;

`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
  logic                  lock;
  logic [SEL_WIDTH-1:0]  lock_src;
  logic                  win_last;
  logic                  out_last_q;

  mux_param #(
    .NUM_INPUT (NUM_INPUT),
    .SEL_WIDTH (SEL_WIDTH),
    .DATA_WIDTH(1)
  ) u_last_mux (
    .sel     (win),
    .data_in (bus.in_last),
    .data_out(win_last)
  );

  assign bus.out_last = out_last_q;

  // While locked, only lock_src may compete, even when it is idle.
  always_comb begin
    req = bus.in_valid;
    if (lock) begin
      req = '0;
      for (int unsigned i = 0; i < NUM_INPUT; i++) begin
        if (lock_src == SEL_WIDTH'(i)) req[i] = bus.in_valid[i];
      end
    end
  end
`else
  assign req = bus.in_valid;
`endif

  rr_pick #(
    .NUM_INPUT(NUM_INPUT),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .winner(win),
    .found (found)
  );

  mux_param #(
    .NUM_INPUT (NUM_INPUT),
    .SEL_WIDTH (SEL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_data_mux (
    .sel     (win),
    .data_in (bus.in_data),
    .data_out(mux_data)
  );

  assign bus.out_valid = (state == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign slot_free     = !bus.out_valid || bus.out_ready;

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NUM_INPUT; i++) begin
      if (rst_n && slot_free && found && (win == SEL_WIDTH'(i))) grant[i] = 1'b1;
    end
  end

  assign bus.in_ready = grant;
  assign accept       = |grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      ptr        <= '0;
      out_data_q <= '0;
      out_src_q  <= '0;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
      lock       <= 1'b0;
      lock_src   <= '0;
      out_last_q <= 1'b0;
`endif
    end else if (accept) begin
      state      <= ST_FULL;
      out_data_q <= mux_data;
      out_src_q  <= win;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
      out_last_q <= win_last;
      if (win_last) begin
        lock <= 1'b0;
        ptr  <= SEL_WIDTH'(next_ptr(32'(win), NUM_INPUT));
      end else begin
        lock     <= 1'b1;
        lock_src <= win;
      end
`else
      ptr        <= SEL_WIDTH'(next_ptr(32'(win), NUM_INPUT));
`endif
    end else if (bus.out_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.NUM_INPUT(N), .SEL_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

  mux_rr_arbiter #(
    .NUM_INPUT (N),
    .SEL_WIDTH (SW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec        = 0;
  int n_miscompare = 0;

  // Model of the output slot and round-robin pointer
  bit         m_valid;
  logic [7:0] m_data;
  int         m_src;
  int         m_ptr;
  int         last_w;

  logic [N*DW-1:0] pat;
  logic [N-1:0]    pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    int w;
    #1;
    exp_ready = '0;
    w = -1;
    if (rst_n && (!m_valid || bus.out_ready)) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (w < 0 && bus.in_valid[idx]) w = idx;
      end
    end
    if (w >= 0) exp_ready[w] = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 0;
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_data  = bus.in_data[w*DW +: DW];
      m_src   = w;
      m_ptr   = (w + 1) % N;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    last_w = w;
    @(negedge clk);
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("out_src", 32'(bus.out_src), m_src);
  endtask

  initial begin
    pat = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; last_w = -1;
    rst_n         = 1'b0;
    bus.in_valid  = '1;
    bus.in_data   = pat;
    bus.out_ready = 1'b1;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    bus.in_last   = '1;
`endif

    // Reset with all requesters valid
    repeat (2) cycle();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_src", 32'(bus.out_src), 32'd0);

    // Full rotation with everyone valid
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("rr_src", 32'(bus.out_src), 32'(k % 4));
      check("rr_data", 32'(bus.out_data), 32'(8'hA0 + k % 4));
    end

    // Sparse requesters 1 and 3
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("sparse_src", 32'(bus.out_src), (k % 2 == 0) ? 32'd1 : 32'd3);
      check("sparse_even_ready", 32'(bus.in_ready & 4'b0101), 32'd0);
    end

    // Backpressure after a grant to input 2
    bus.in_valid = 4'b0100;
    cycle();
    check("bp_src", 32'(bus.out_src), 32'd2);
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("bp_hold_src", 32'(bus.out_src), 32'd2);
      check("bp_hold_data", 32'(bus.out_data), 32'hA2);
      check("bp_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    cycle();
    check("bp_release_src", 32'(bus.out_src), 32'd3);

    // Wrap from 3 to 0, then pointer sits at 1
    bus.in_valid = 4'b0001;
    cycle();
    check("wrap_src", 32'(bus.out_src), 32'd0);
    bus.in_valid = 4'b1111;
    cycle();
    check("wrap_next_src", 32'(bus.out_src), 32'd1);

    // Random traffic; requesters hold valid/data until accepted
    pending = '0;
    for (int t = 0; t < 400; t++) begin
      rst_n         = ($urandom_range(99) != 0);
      bus.out_ready = ($urandom_range(99) < 70);
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(1) == 1) begin
          pending[i] = 1'b1;
          bus.in_data[i*DW +: DW] = 8'($urandom);
        end
      end
      bus.in_valid = pending;
      cycle();
      if (last_w >= 0) pending[last_w] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
